sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 1037, meaning clocks between refresh requests (7.8 us at 133 MHz).
REQ-002 SHALL have parameter MAX_WR_SKIP, default 2, meaning the maximum consecutive read grants while a write waits.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_clk  in  1  SDRAM clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port i_wr_req  in  1  capture FIFO holds a line to store (level).
REQ-007 SHALL have port i_wr_line  in  9  line index of the pending write.
REQ-008 SHALL have port o_wr_ack  out  1  one-cycle pulse when the write burst completes.
REQ-009 SHALL have port i_rd_req  in  1  video output needs a line fetched (level).
REQ-010 SHALL have port i_rd_line  in  9  line index to fetch.
REQ-011 SHALL have port o_rd_ack  out  1  one-cycle pulse when the read burst completes.
REQ-012 SHALL have port o_cmd_valid  out  1  command offered to the SDRAM controller.
REQ-013 SHALL have port o_cmd_op  out  2  00 none, 01 write, 10 read, 11 refresh.
REQ-014 SHALL have port o_cmd_line  out  9  line index of the offered command; 0 for refresh.
REQ-015 SHALL have port i_cmd_ready  in  1  controller accepts the offered command.
REQ-016 SHALL have port i_cmd_done  in  1  one-cycle pulse when the accepted command finishes.
REQ-017 SHALL have port o_busy  out  1  high whenever the FSM is not IDLE.
REQ-018 SHALL have port o_ref_overrun  out  1  sticky: a refresh came due while the previous one was still pending.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE and WAIT_DONE.
REQ-020 In IDLE, SHALL select one request by this priority, latch its op and line, and enter ISSUE on the next edge:
- refresh pending, then
- read, then
- write.
REQ-021 SHALL override read priority when i_wr_req is high and the skip counter equals MAX_WR_SKIP; the write then wins.
REQ-022 SHALL increment the skip counter (saturating at MAX_WR_SKIP) on each read grant made while i_wr_req is high.
REQ-023 SHALL clear the skip counter on every write grant.
REQ-024 In ISSUE, SHALL hold o_cmd_valid=1 with stable o_cmd_op and o_cmd_line until i_cmd_ready=1, then enter WAIT_DONE.
REQ-025 A request sampled in IDLE at cycle N SHALL produce o_cmd_valid=1 at cycle N+1.
REQ-026 In WAIT_DONE, on i_cmd_done=1, SHALL:
- pulse o_wr_ack for a write or o_rd_ack for a read, in the next cycle;
- clear refresh-pending for a refresh;
- return to IDLE.
REQ-027 SHALL ignore i_cmd_done outside WAIT_DONE; i_cmd_done arriving in the same cycle as i_cmd_ready SHALL be ignored.
REQ-028 Requests dropped while in ISSUE or WAIT_DONE SHALL NOT abort the latched command.
REQ-029 The refresh down-counter SHALL run in every state.
- It loads REFRESH_CYCLES-1 and, on reaching 0, sets refresh-pending and reloads.
- If refresh-pending is already set at that moment, it SHALL set o_ref_overrun.
REQ-030 The skip counter SHALL be clog2(MAX_WR_SKIP+1) bits wide; the refresh counter SHALL be clog2(REFRESH_CYCLES) bits wide.
REQ-031 SHALL drive o_cmd_op=00 and o_cmd_line=0 whenever o_cmd_valid=0.

Reset
REQ-032 On i_reset=1, SHALL enter IDLE and drive:
- o_cmd_valid=0, o_cmd_op=00, o_cmd_line=0;
- o_wr_ack=0, o_rd_ack=0, o_busy=0, o_ref_overrun=0.
REQ-033 On i_reset=1, SHALL also clear refresh-pending and the skip counter and reload the refresh counter; this applies mid-command too, with no completion ack issued.
REQ-034 The first refresh request SHALL come due REFRESH_CYCLES clocks after reset deasserts.

Structure
REQ-035 Op codes and the FSM state encoding SHALL reside in shared package sdram_arb_pkg.
REQ-036 The refresh counter with its pending and overrun logic SHALL be sub-module sdram_refresh_timer.

Verification
REQ-037 Single read: i_rd_req=1, line 0x05; i_cmd_ready at N+2; i_cmd_done at N+6 -> valid op=10 line=0x05 N+1..N+2; o_rd_ack pulse at N+7.
REQ-038 Contention: i_rd_req and i_wr_req held high, MAX_WR_SKIP=2, immediate ready/done -> grant order R,R,W,R,R,W.
REQ-039 Refresh: REFRESH_CYCLES=16, no requests -> op=11 offered at cycle 17 after reset; accepted once per 16 cycles; o_ref_overrun stays 0.
REQ-040 Overrun: REFRESH_CYCLES=16, i_cmd_ready held low for 40 cycles -> o_ref_overrun=1 at cycle 32 and stays 1.
REQ-041 Reset mid-command: i_reset asserted in WAIT_DONE -> next cycle all outputs 0; no ack; later i_cmd_done is ignored.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared op codes, FSM encoding and the latched-command record for the SDRAM arbiter.
package sdram_arb_pkg;

    localparam int unsigned LINE_W = 9;

    // Command op codes as seen on o_cmd_op
    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_REFRESH = 2'b11;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_ISSUE     = 2'b01;
    localparam logic [1:0] ST_WAIT_DONE = 2'b10;

    typedef struct packed {
        logic [1:0]        op;
        logic [LINE_W-1:0] line;
    } cmd_t;

    // clog2 that never yields a zero-width vector
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer with a pending flag and a sticky overrun flag.
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1037
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ref_clear,
    output logic o_ref_pending,
    output logic o_ref_overrun
);

    localparam int unsigned CNT_W = clog2_min1(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             tick;

    // Down-count, raise pending on expiry; a new expiry wins over a same-cycle clear
    always_comb begin
        tick      = (cnt_q == '0);
        cnt_d     = tick ? RELOAD : cnt_q - CNT_W'(1);
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (tick) begin
            pending_d = 1'b1;
            if (pending_q && !i_ref_clear) begin
                overrun_d = 1'b1;
            end
        end else if (i_ref_clear) begin
            pending_d = 1'b0;
        end
    end

    // Timer state registers, synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_ref_pending = pending_q;
    assign o_ref_overrun = overrun_q;

endmodule

// File: rtl/sdram_arb.sv
// Arbitrates refresh, line-read and line-write requests onto a single SDRAM command port.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1037,
    parameter int unsigned MAX_WR_SKIP    = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_req,
    input  logic [LINE_W-1:0] i_wr_line,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [LINE_W-1:0] i_rd_line,
    output logic              o_rd_ack,
    output logic              o_cmd_valid,
    output logic [1:0]        o_cmd_op,
    output logic [LINE_W-1:0] o_cmd_line,
    input  logic              i_cmd_ready,
    input  logic              i_cmd_done,
    output logic              o_busy,
    output logic              o_ref_overrun
);

    localparam int unsigned SKIP_W = clog2_min1(MAX_WR_SKIP + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_WR_SKIP);

    logic [1:0]        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              ref_pending;
    logic              ref_clear;
    logic              wr_forced;

    sdram_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_ref_clear   (ref_clear),
        .o_ref_pending (ref_pending),
        .o_ref_overrun (o_ref_overrun)
    );

    // A waiting write overtakes reads once it has been passed over MAX_WR_SKIP times
    assign wr_forced = i_wr_req && (skip_q == SKIP_MAX);

    // Next-state: grant in IDLE, hold the offer in ISSUE, await completion in WAIT_DONE
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        skip_d    = skip_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        ref_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ref_pending) begin
                    cmd_d.op   = OP_REFRESH;
                    cmd_d.line = '0;
                    state_d    = ST_ISSUE;
                end else if (i_rd_req && !wr_forced) begin
                    cmd_d.op   = OP_READ;
                    cmd_d.line = i_rd_line;
                    state_d    = ST_ISSUE;
                    if (i_wr_req && (skip_q != SKIP_MAX)) begin
                        skip_d = skip_q + SKIP_W'(1);
                    end
                end else if (i_wr_req) begin
                    cmd_d.op   = OP_WRITE;
                    cmd_d.line = i_wr_line;
                    state_d    = ST_ISSUE;
                    skip_d     = '0;
                end
            end
            ST_ISSUE: begin
                if (i_cmd_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_cmd_done) begin
                    state_d = ST_IDLE;
                    case (cmd_q.op)
                        OP_WRITE:   wr_ack_d  = 1'b1;
                        OP_READ:    rd_ack_d  = 1'b1;
                        OP_REFRESH: ref_clear = 1'b1;
                        default:    ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers; reset mid-command drops the command without an ack
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            skip_q   <= '0;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            skip_q   <= skip_d;
            wr_ack_q <= wr_ack_d;
            rd_ack_q <= rd_ack_d;
        end
    end

    assign o_cmd_valid = (state_q == ST_ISSUE);
    assign o_cmd_op    = o_cmd_valid ? cmd_q.op : OP_NONE;
    assign o_cmd_line  = o_cmd_valid ? cmd_q.line : '0;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_wr_ack    = wr_ack_q;
    assign o_rd_ack    = rd_ack_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: one instance with a long refresh interval for request
// handling, one with REFRESH_CYCLES=16 for refresh timing and overrun.
module tb_sdram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: request path
    logic       a_reset, a_wr_req, a_rd_req, a_cmd_ready, a_cmd_done;
    logic [8:0] a_wr_line, a_rd_line, a_cmd_line;
    logic       a_wr_ack, a_rd_ack, a_cmd_valid, a_busy, a_ref_overrun;
    logic [1:0] a_cmd_op;

    // Instance R: refresh path
    logic       r_reset, r_wr_req, r_rd_req, r_cmd_ready, r_cmd_done;
    logic [8:0] r_wr_line, r_rd_line, r_cmd_line;
    logic       r_wr_ack, r_rd_ack, r_cmd_valid, r_busy, r_ref_overrun;
    logic [1:0] r_cmd_op;

    sdram_arb #(
        .REFRESH_CYCLES (1037),
        .MAX_WR_SKIP    (2)
    ) dut_a (
        .i_clk         (clk),
        .i_reset       (a_reset),
        .i_wr_req      (a_wr_req),
        .i_wr_line     (a_wr_line),
        .o_wr_ack      (a_wr_ack),
        .i_rd_req      (a_rd_req),
        .i_rd_line     (a_rd_line),
        .o_rd_ack      (a_rd_ack),
        .o_cmd_valid   (a_cmd_valid),
        .o_cmd_op      (a_cmd_op),
        .o_cmd_line    (a_cmd_line),
        .i_cmd_ready   (a_cmd_ready),
        .i_cmd_done    (a_cmd_done),
        .o_busy        (a_busy),
        .o_ref_overrun (a_ref_overrun)
    );

    sdram_arb #(
        .REFRESH_CYCLES (16),
        .MAX_WR_SKIP    (2)
    ) dut_r (
        .i_clk         (clk),
        .i_reset       (r_reset),
        .i_wr_req      (r_wr_req),
        .i_wr_line     (r_wr_line),
        .o_wr_ack      (r_wr_ack),
        .i_rd_req      (r_rd_req),
        .i_rd_line     (r_rd_line),
        .o_rd_ack      (r_rd_ack),
        .o_cmd_valid   (r_cmd_valid),
        .o_cmd_op      (r_cmd_op),
        .o_cmd_line    (r_cmd_line),
        .i_cmd_ready   (r_cmd_ready),
        .i_cmd_done    (r_cmd_done),
        .o_busy        (r_busy),
        .o_ref_overrun (r_ref_overrun)
    );

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [8:0] rl;
        logic [8:0] wl;
        logic       rdy;
        logic       dn;
        logic       v;
        logic [1:0] op;
        logic [8:0] line;
        logic       wa;
        logic       ra;
        logic       b;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return the caller is in cycle 0 (first cycle with reset low)
    task automatic reset_a();
        a_reset = 1'b1; a_wr_req = 1'b0; a_rd_req = 1'b0; a_wr_line = '0; a_rd_line = '0;
        a_cmd_ready = 1'b0; a_cmd_done = 1'b0;
        tick(); tick();
        a_reset = 1'b0;
    endtask

    task automatic reset_r();
        r_reset = 1'b1; r_wr_req = 1'b0; r_rd_req = 1'b0; r_wr_line = '0; r_rd_line = '0;
        r_cmd_ready = 1'b0; r_cmd_done = 1'b0;
        tick(); tick();
        r_reset = 1'b0;
    endtask

    initial begin
        int        n;
        int        got_op [6];
        int        got_ln [6];
        int        exp_op [6];
        logic      ev;

        // rd wr rl wl rdy dn | v op line wa ra busy
        vecs[0]  = '{1'b1, 1'b0, 9'h005, 9'h000, 1'b0, 1'b1, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 9'h005, 9'h000, 1'b0, 1'b1, 1'b1, 2'd2, 9'h005, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 1'b1, 2'd2, 9'h005, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 9'h000, 9'h1A3, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 9'h000, 9'h0FF, 1'b0, 1'b0, 1'b1, 2'd1, 9'h1A3, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 9'h000, 9'h0FF, 1'b1, 1'b1, 1'b1, 2'd1, 9'h1A3, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b1, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0, 1'b0};

        exp_op = '{2, 2, 1, 2, 2, 1};

        reset_a();
        reset_r();

        // Reset state
        check("reset.valid", int'(a_cmd_valid), 0);
        check("reset.op", int'(a_cmd_op), 0);
        check("reset.busy", int'(a_busy), 0);
        check("reset.overrun", int'(a_ref_overrun), 0);

        // Single read then single write, cycle by cycle
        reset_a();
        for (int i = 0; i < 16; i++) begin
            a_rd_req = vecs[i].rd; a_wr_req = vecs[i].wr;
            a_rd_line = vecs[i].rl; a_wr_line = vecs[i].wl;
            a_cmd_ready = vecs[i].rdy; a_cmd_done = vecs[i].dn;
            check($sformatf("vec%0d.valid", i), int'(a_cmd_valid), int'(vecs[i].v));
            check($sformatf("vec%0d.op", i), int'(a_cmd_op), int'(vecs[i].op));
            check($sformatf("vec%0d.line", i), int'(a_cmd_line), int'(vecs[i].line));
            check($sformatf("vec%0d.wr_ack", i), int'(a_wr_ack), int'(vecs[i].wa));
            check($sformatf("vec%0d.rd_ack", i), int'(a_rd_ack), int'(vecs[i].ra));
            check($sformatf("vec%0d.busy", i), int'(a_busy), int'(vecs[i].b));
            tick();
        end

        // Contention with immediate ready/done: expect R,R,W,R,R,W
        reset_a();
        a_rd_req = 1'b1; a_wr_req = 1'b1; a_rd_line = 9'h011; a_wr_line = 9'h022;
        a_cmd_ready = 1'b1; a_cmd_done = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            if (a_cmd_valid) begin
                got_op[n] = int'(a_cmd_op);
                got_ln[n] = int'(a_cmd_line);
                n++;
            end
            tick();
        end
        check("contention.count", n, 6);
        for (int i = 0; i < n; i++) begin
            check($sformatf("contention.op%0d", i), got_op[i], exp_op[i]);
            check($sformatf("contention.line%0d", i), got_ln[i],
                  (exp_op[i] == 2) ? 'h011 : 'h022);
        end

        // Reset mid-command: no ack, later done ignored
        reset_a();
        a_rd_req = 1'b1; a_rd_line = 9'h007;
        tick();
        a_rd_req = 1'b0; a_cmd_ready = 1'b1;
        tick();
        a_cmd_ready = 1'b0;
        check("midrst.busy_before", int'(a_busy), 1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0; a_cmd_done = 1'b1;
        check("midrst.busy", int'(a_busy), 0);
        check("midrst.valid", int'(a_cmd_valid), 0);
        check("midrst.op", int'(a_cmd_op), 0);
        check("midrst.line", int'(a_cmd_line), 0);
        check("midrst.rd_ack", int'(a_rd_ack), 0);
        tick();
        a_cmd_done = 1'b0;
        check("midrst.rd_ack_late", int'(a_rd_ack), 0);
        check("midrst.busy_late", int'(a_busy), 0);
        tick();
        check("midrst.rd_ack_late2", int'(a_rd_ack), 0);

        // Periodic refresh: offered at cycles 17, 33, 49
        reset_r();
        r_cmd_ready = 1'b1; r_cmd_done = 1'b1;
        for (int c = 0; c < 60; c++) begin
            ev = (c == 17) || (c == 33) || (c == 49);
            check($sformatf("refresh.valid@%0d", c), int'(r_cmd_valid), int'(ev));
            if (ev) begin
                check($sformatf("refresh.op@%0d", c), int'(r_cmd_op), 3);
                check($sformatf("refresh.line@%0d", c), int'(r_cmd_line), 0);
            end
            tick();
        end
        check("refresh.overrun", int'(r_ref_overrun), 0);

        // Refresh beats a read that arrives the same cycle refresh is pending
        reset_r();
        r_cmd_ready = 1'b1; r_cmd_done = 1'b1; r_rd_line = 9'h009;
        for (int c = 0; c <= 20; c++) begin
            r_rd_req = (c >= 16);
            if (c == 17) check("prio.op17", int'(r_cmd_op), 3);
            if (c == 18) check("prio.valid18", int'(r_cmd_valid), 0);
            if (c == 20) begin
                check("prio.op20", int'(r_cmd_op), 2);
                check("prio.line20", int'(r_cmd_line), 9);
            end
            tick();
        end

        // Overrun: ready held low, sticky from cycle 32
        reset_r();
        for (int c = 0; c <= 40; c++) begin
            check($sformatf("overrun@%0d", c), int'(r_ref_overrun), int'(c >= 32));
            if (c == 20 || c == 40) check($sformatf("overrun.valid@%0d", c), int'(r_cmd_valid), 1);
            tick();
        end
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        check("overrun.after_reset", int'(r_ref_overrun), 0);
        check("overrun.valid_after_reset", int'(r_cmd_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
